prog_store_seq: RTL and testbench
=================================

# prog_store_seq

Parametrised program store and run-control sequencer for the model CPU. Holds BANKS program images written through the edit port (edit/unit/code/send), serves instruction words to the CPU fetch port, and issues step enables in single-step, timed-run or speed-run mode. Run modes stop automatically on the HALT opcode. It replaces the fixed 8-bit, single-rate program ROM front end and adds bank select, clear sweep, pause and run-rate division.

## Interface
- DATA_W, 8, instruction word width
- ADDR_W, 8, word address width; each bank holds 2**ADDR_W words
- BANKS, 4, number of program banks (power of two, ≥1)
- HALT_CODE, 8'b00110010, opcode that stops the run modes (DATA_W wide)
- SPEED_DIV, 4, RUN-mode step period in cycles (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rstROM  in  1  rise starts a full memory clear sweep
- edit  in  1  level; high = edit mode
- unit  in  ADDR_W  edit write address
- code  in  DATA_W  edit write data
- send  in  1  rise = write code to mem[bank][unit]
- program  in  $clog2(BANKS) (min 1)  bank select
- NEXT  in  1  rise = single step, or pause when running
- RUN  in  1  rise = timed run
- SPEEDRUN  in  1  rise = run, one step per cycle
- fetch_addr  in  ADDR_W  CPU instruction address
- fetch_data  out  DATA_W  registered word at fetch_addr
- step_en  out  1  one-cycle CPU advance strobe
- write_ack  out  1  one-cycle pulse after an edit write
- busy  out  1  clear sweep in progress
- halted  out  1  HALT_CODE reached
- mode  out  2  0 idle, 1 run, 2 speedrun, 3 halted

## Operation
- Reset values: fetch_data 0, step_en 0, write_ack 0, busy 0, halted 0, mode 0, state IDLE, active bank 0. Memory contents are not reset.
- States: IDLE, CLEAR, RUN, SPEED, HALTED.
- Command inputs (rstROM, send, NEXT, RUN, SPEEDRUN, edit) are registered once. A rise is current=1 and previous=0. Each command acts at the edge where the rise is first seen. Held levels never repeat an action.
- Priority at one edge: rstROM > edit-level gating > SPEEDRUN > RUN > NEXT.
- CLEAR (any state except CLEAR, on rstROM rise):
  - Writes 0 to every word, one word per cycle, across all banks: BANKS·2**ADDR_W cycles.
  - busy is high throughout. fetch_data reads 0.
  - All other commands are ignored.
  - Ends in IDLE with halted=0.
- Edit (edit=1, not CLEAR):
  - A send rise writes code into mem[program][unit]. write_ack is high the next cycle.
  - Run commands are ignored while edit=1.
  - edit=1 in RUN, SPEED or HALTED forces IDLE and clears halted.
- Active bank: program is latched in IDLE only. Changes in RUN/SPEED have no effect until IDLE.
- IDLE:
  - NEXT rise → one step_en pulse if fetch_data≠HALT_CODE. Otherwise → HALTED.
  - RUN rise → RUN. SPEEDRUN rise → SPEED.
- RUN: step_en at entry edge, then every SPEED_DIV cycles.
- SPEED: step_en every cycle.
- RUN/SPEED shared rules:
  - At any edge where step_en would fire and fetch_data==HALT_CODE: suppress step_en, go HALTED, set halted=1.
  - NEXT rise → IDLE (pause, no step).
  - RUN↔SPEEDRUN rise switches mode and restarts the divider.
- HALTED: NEXT, RUN and SPEEDRUN are ignored. Leaves only via edit=1 or rstROM.
- Read/write collision at the same address: fetch_data returns the old word (read-first).

## Timing
- fetch_data latency is 1 cycle from fetch_addr.
- Edit write: memory updated at the send-rise edge. write_ack follows one cycle later.
- Command latency: 2 edges from the input pin (1 register + action edge).
- The RUN divider counts 0..SPEED_DIV-1 and wraps. step_en fires at count 0.
- A reset (rst low) mid-CLEAR aborts the sweep. Partly cleared memory is left as is.

## Configuration
- PROG_STORE_BREAKPOINT_EN defined:
  - Adds ports bp_addr (in, ADDR_W), bp_en (in, 1) and bp_hit (out, 1, reset 0).
  - In RUN/SPEED, if bp_en and fetch_addr==bp_addr at a step edge, the step is suppressed, state goes to IDLE, and bp_hit pulses for one cycle.
  - IDLE single-step ignores breakpoints.
- Undefined: these ports and this logic are absent.

## Structure
- prog_store_pkg holds:
  - the state enum;
  - mode encodings;
  - the default HALT_CODE constant.
- One sub-module, rise_detect: a parametrised-width input register with a rise output. It is instanced for all command inputs.
- Memory is an inferred array with a registered read.

## Test plan
- Edit write: edit=1, program=1, write 0x2A to unit 5 → write_ack one cycle later. With edit=0 and fetch_addr=5 → fetch_data=0x2A next cycle. Bank 0 addr 5 is unchanged.
- RUN, default SPEED_DIV=4, bank 0, no HALT_CODE present → step_en pulses at cycles 0, 4, 8… after the action edge. NEXT rise → mode=0 and step_en stops.
- SPEEDRUN with fetch_addr stepping 0,1,2 and HALT_CODE at addr 2 → step_en at addr 0 and addr 1 only. Then halted=1 and mode=3. A following RUN rise is ignored.
- rstROM rise with ADDR_W=4, BANKS=2 → busy high for exactly 32 cycles. All words read 0. send during the sweep is ignored (no write_ack).
- Priority: RUN and SPEEDRUN rise on the same edge → mode=2. SPEEDRUN rise with edit=1 → no step_en.
- Breakpoint (macro defined): bp_addr=3, bp_en=1, SPEEDRUN from addr 0 → step_en for addr 0–2. bp_hit pulse at addr 3, then mode=0.

Source files
------------

// File: rtl/prog_store_pkg.sv
// prog_store_pkg: shared sequencer states, mode encodings and default HALT opcode
// No ports; imported by prog_store_seq.
package prog_store_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_SPEED, S_HALTED} state_t;
    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_RUN   = 2'd1;
    localparam logic [1:0] MODE_SPEED = 2'd2;
    localparam logic [1:0] MODE_HALT  = 2'd3;
    localparam logic [7:0] HALT_DEFAULT = 8'b00110010;
endpackage

// File: rtl/prog_store_seq_rise_detect.sv
// rise_detect: registers W command inputs once and flags a rise (current=1, previous=0)
// Ports: clk, rst (async active-low), din (raw inputs), q (registered level), rise (one-cycle rise flag)
module rise_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);
    logic [W-1:0] prev;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            prev <= '0;
        end else begin
            q    <= din;
            prev <= q;
        end
    end
    assign rise = q & ~prev;
endmodule

// File: rtl/prog_store_seq.sv
// prog_store_seq: banked program store with edit port, clear sweep and step/run/speed-run sequencer
// Ports: clk, rst (async active-low); rstROM (clear sweep); edit/unit/code/send (edit writes);
//   program_sel (bank select); NEXT/RUN/SPEEDRUN (run control); fetch_addr/fetch_data (CPU fetch);
//   step_en, write_ack, busy, halted, mode (status).
// Optional macro PROG_STORE_BREAKPOINT_EN adds bp_addr, bp_en, bp_hit.
module prog_store_seq
    import prog_store_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int BANKS     = 4,
    parameter logic [DATA_W-1:0] HALT_CODE = DATA_W'(HALT_DEFAULT),
    parameter int SPEED_DIV = 4,
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rstROM,
    input  logic              edit,
    input  logic [ADDR_W-1:0] unit,
    input  logic [DATA_W-1:0] code,
    input  logic              send,
    input  logic [BW-1:0]     program_sel,
    input  logic              NEXT,
    input  logic              RUN,
    input  logic              SPEEDRUN,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              step_en,
    output logic              write_ack,
    output logic              busy,
    output logic              halted,
`ifdef PROG_STORE_BREAKPOINT_EN
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    output logic              bp_hit,
`endif
    output logic [1:0]        mode
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MW = $clog2(BANKS * DEPTH);
    localparam int DW = $clog2(SPEED_DIV);
    localparam logic [BW-1:0] BMASK = BW'(BANKS - 1);
    localparam logic [MW-1:0] LAST = MW'(BANKS * DEPTH - 1);

    state_t state, state_n;
    logic [DATA_W-1:0] mem [BANKS*DEPTH];
    logic [BW-1:0] bank;
    logic [MW-1:0] clr_cnt;
    logic [DW-1:0] div, div_n;
    logic step_n, fire, wr;
    logic [5:0] cmd_q, cmd_rise;
    logic unused_cmd;
`ifdef PROG_STORE_BREAKPOINT_EN
    logic bp_n;
`endif

    // bit order: 0 rstROM, 1 send, 2 NEXT, 3 RUN, 4 SPEEDRUN, 5 edit
    rise_detect #(.W(6)) u_cmd (
        .clk(clk),
        .rst(rst),
        .din({edit, SPEEDRUN, RUN, NEXT, send, rstROM}),
        .q(cmd_q),
        .rise(cmd_rise)
    );
    assign unused_cmd = ^{cmd_q[4:0], cmd_rise[5]};

    // flat word index; the bank mask collapses the bank field when BANKS == 1
    function automatic logic [MW-1:0] word(input logic [BW-1:0] b, input logic [ADDR_W-1:0] a);
        return MW'({b & BMASK, a});
    endfunction

    assign wr = cmd_q[5] && cmd_rise[1] && !cmd_rise[0] && state != S_CLEAR;

    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr)
            mem[word(program_sel, unit)] <= code;
    end

    always_comb begin
        state_n = state;
        div_n   = div;
        step_n  = 1'b0;
        fire    = 1'b0;
`ifdef PROG_STORE_BREAKPOINT_EN
        bp_n    = 1'b0;
`endif
        if (cmd_rise[0] && state != S_CLEAR)
            state_n = S_CLEAR;
        else if (state == S_CLEAR)
            state_n = (clr_cnt == LAST) ? S_IDLE : S_CLEAR;
        else if (cmd_q[5])
            state_n = S_IDLE;
        else if (state != S_HALTED) begin
            if (cmd_rise[4]) begin
                state_n = S_SPEED;
                fire    = 1'b1;
            end else if (cmd_rise[3]) begin
                state_n = S_RUN;
                div_n   = DW'(1);
                fire    = 1'b1;
            end else if (cmd_rise[2]) begin
                state_n = S_IDLE;
                fire    = (state == S_IDLE);
            end else if (state != S_IDLE) begin
                fire  = (state == S_SPEED) || (div == '0);
                div_n = (div == DW'(SPEED_DIV - 1)) ? '0 : div + 1'b1;
            end
        end
        // state_n == S_IDLE here means an IDLE single step, which ignores breakpoints
        if (fire) begin
`ifdef PROG_STORE_BREAKPOINT_EN
            if (bp_en && fetch_addr == bp_addr && state_n != S_IDLE) begin
                state_n = S_IDLE;
                bp_n    = 1'b1;
            end else
`endif
            if (fetch_data == HALT_CODE)
                state_n = S_HALTED;
            else
                step_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            div        <= '0;
            clr_cnt    <= '0;
            bank       <= '0;
            fetch_data <= '0;
            step_en    <= 1'b0;
            write_ack  <= 1'b0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            clr_cnt    <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
            bank       <= (state == S_IDLE) ? program_sel : bank;
            fetch_data <= (state == S_CLEAR || state_n == S_CLEAR) ? '0 : mem[word(bank, fetch_addr)];
            step_en    <= step_n;
            write_ack  <= wr;
        end
    end

`ifdef PROG_STORE_BREAKPOINT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bp_hit <= 1'b0;
        else
            bp_hit <= bp_n;
    end
`endif

    assign busy   = (state == S_CLEAR);
    assign halted = (state == S_HALTED);
    assign mode   = (state == S_RUN)    ? MODE_RUN   :
                    (state == S_SPEED)  ? MODE_SPEED :
                    (state == S_HALTED) ? MODE_HALT  : MODE_IDLE;
endmodule

// File: tb/tb_prog_store_seq.sv
// tb_prog_store_seq: directed self-checking bench for prog_store_seq (ADDR_W=4, BANKS=2)
module tb_prog_store_seq;
    localparam logic [7:0] HALT = 8'b00110010;

    logic clk = 0, rst = 0, rstROM = 0, edit = 0, send = 0, NEXT = 0, RUN = 0, SPEEDRUN = 0;
    logic [3:0] unit = 0, fetch_addr = 0;
    logic [7:0] code = 0;
    logic program_sel = 0;
    logic [7:0] fetch_data;
    logic step_en, write_ack, busy, halted;
    logic [1:0] mode;
`ifdef PROG_STORE_BREAKPOINT_EN
    logic [3:0] bp_addr = 0;
    logic bp_en = 0;
    logic bp_hit;
`endif
    int errors = 0, checks = 0;

    prog_store_seq #(.DATA_W(8), .ADDR_W(4), .BANKS(2)) dut (
        .clk(clk), .rst(rst), .rstROM(rstROM), .edit(edit), .unit(unit), .code(code),
        .send(send), .program_sel(program_sel), .NEXT(NEXT), .RUN(RUN), .SPEEDRUN(SPEEDRUN),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data), .step_en(step_en),
        .write_ack(write_ack), .busy(busy), .halted(halted),
`ifdef PROG_STORE_BREAKPOINT_EN
        .bp_addr(bp_addr), .bp_en(bp_en), .bp_hit(bp_hit),
`endif
        .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic b, input logic [3:0] a, input logic [7:0] d);
        program_sel = b; unit = a; code = d; edit = 1; send = 1;
        repeat (3) @(negedge clk);
        send = 0; edit = 0; program_sel = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (fetch_data !== 8'h00) begin errors++; $display("FAIL rst_fetch_data: got %0h expected 0", fetch_data); end
        checks++; if (step_en !== 1'b0) begin errors++; $display("FAIL rst_step_en: got %0b expected 0", step_en); end
        checks++; if (write_ack !== 1'b0) begin errors++; $display("FAIL rst_write_ack: got %0b expected 0", write_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b expected 0", halted); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_mode: got %0d expected 0", mode); end
`ifdef PROG_STORE_BREAKPOINT_EN
        checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL rst_bp_hit: got %0b expected 0", bp_hit); end
`endif
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_clear;
        int nbusy = 0, nack = 0, nfd = 0, bad = 0;
        rstROM = 1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin nbusy++; if (fetch_data !== 8'h00) nfd++; end
            if (write_ack === 1'b1) nack++;
            if (i == 2) rstROM = 0;
            if (i == 5) begin edit = 1; send = 1; unit = 4'd7; code = 8'h99; end
            if (i == 8) send = 0;
        end
        edit = 0;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            program_sel = b[0];
            repeat (2) @(negedge clk);
            for (int a = 0; a < 16; a++) begin
                fetch_addr = a[3:0];
                @(negedge clk);
                if (fetch_data !== 8'h00) bad++;
            end
        end
        program_sel = 0;
        checks++; if (nbusy != 32) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 32", nbusy); end
        checks++; if (nfd != 0) begin errors++; $display("FAIL clear_fetch_zero: got %0d nonzero expected 0", nfd); end
        checks++; if (nack != 0) begin errors++; $display("FAIL clear_send_ignored: got %0d acks expected 0", nack); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_words: got %0d nonzero words expected 0", bad); end
    endtask

    task automatic test_edit;
        program_sel = 1; fetch_addr = 4'd5; unit = 4'd5; code = 8'h2A; edit = 1; send = 1;
        @(negedge clk);
        checks++; if (write_ack !== 1'b0) begin errors++; $display("FAIL wack_early: got %0b expected 0", write_ack); end
        @(negedge clk);
        checks++; if (write_ack !== 1'b1) begin errors++; $display("FAIL wack_pulse: got %0b expected 1", write_ack); end
        @(negedge clk);
        checks++; if (write_ack !== 1'b0) begin errors++; $display("FAIL wack_end: got %0b expected 0", write_ack); end
        send = 0; edit = 0;
        @(negedge clk);
        checks++; if (fetch_data !== 8'h2A) begin errors++; $display("FAIL edit_readback: got %0h expected 2a", fetch_data); end
        code = 8'h55; edit = 1; send = 1;
        repeat (2) @(negedge clk);
        checks++; if (fetch_data !== 8'h2A) begin errors++; $display("FAIL read_first: got %0h expected 2a", fetch_data); end
        @(negedge clk);
        checks++; if (fetch_data !== 8'h55) begin errors++; $display("FAIL after_overwrite: got %0h expected 55", fetch_data); end
        send = 0; edit = 0; program_sel = 0;
        repeat (2) @(negedge clk);
        checks++; if (fetch_data !== 8'h00) begin errors++; $display("FAIL bank0_untouched: got %0h expected 0", fetch_data); end
    endtask

    task automatic test_run;
        int n = 0;
        fetch_addr = 0;
        repeat (2) @(negedge clk);
        RUN = 1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (step_en !== ((i % 4) == 0)) begin errors++; $display("FAIL run_step_%0d: got %0b expected %0b", i, step_en, (i % 4) == 0); end
            if (i == 1) begin checks++; if (mode !== 2'd1) begin errors++; $display("FAIL run_mode: got %0d expected 1", mode); end end
            if (i == 2) RUN = 0;
        end
        NEXT = 1;
        repeat (2) @(negedge clk);
        NEXT = 0;
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL pause_mode: got %0d expected 0", mode); end
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (step_en === 1'b1) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL pause_steps: got %0d expected 0", n); end
    endtask

    task automatic test_step;
        int n = 0;
        do_write(1'b0, 4'd2, HALT);
        fetch_addr = 0;
        repeat (2) @(negedge clk);
        NEXT = 1;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (step_en === 1'b1) n++; if (i == 2) NEXT = 0; end
        checks++; if (n != 1) begin errors++; $display("FAIL single_step: got %0d pulses expected 1", n); end
        fetch_addr = 4'd2;
        repeat (2) @(negedge clk);
        NEXT = 1; n = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (step_en === 1'b1) n++; end
        NEXT = 0;
        checks++; if (n != 0) begin errors++; $display("FAIL step_on_halt: got %0d pulses expected 0", n); end
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL step_halt_mode: got %0d expected 3", mode); end
        edit = 1;
        repeat (2) @(negedge clk);
        checks++; if (halted !== 1'b0 || mode !== 2'd0) begin errors++; $display("FAIL edit_unhalt: got halted=%0b mode=%0d expected 0/0", halted, mode); end
        edit = 0;
        @(negedge clk);
    endtask

    task automatic test_speed_halt;
        int n = 0;
        fetch_addr = 0;
        repeat (2) @(negedge clk);
        SPEEDRUN = 1;
        @(negedge clk);
        fetch_addr = 4'd1;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (step_en === 1'b1) n++; if (i == 0) fetch_addr = 4'd2; end
        SPEEDRUN = 0;
        checks++; if (n != 2) begin errors++; $display("FAIL speed_steps: got %0d expected 2", n); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL speed_halted: got %0b expected 1", halted); end
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL speed_halt_mode: got %0d expected 3", mode); end
        RUN = 1; n = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (step_en === 1'b1) n++; end
        RUN = 0;
        checks++; if (n != 0 || mode !== 2'd3) begin errors++; $display("FAIL run_in_halted: got steps=%0d mode=%0d expected 0/3", n, mode); end
        edit = 1;
        repeat (2) @(negedge clk);
        edit = 0;
        @(negedge clk);
    endtask

    task automatic test_priority;
        int n = 0;
        fetch_addr = 0;
        repeat (2) @(negedge clk);
        RUN = 1; SPEEDRUN = 1;
        repeat (2) @(negedge clk);
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL run_speed_same_edge: got %0d expected 2", mode); end
        RUN = 0; SPEEDRUN = 0; NEXT = 1;
        repeat (2) @(negedge clk);
        NEXT = 0;
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL speed_pause: got %0d expected 0", mode); end
        edit = 1; SPEEDRUN = 1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (step_en === 1'b1) n++; end
        checks++; if (n != 0 || mode !== 2'd0) begin errors++; $display("FAIL edit_gates_speed: got steps=%0d mode=%0d expected 0/0", n, mode); end
        edit = 0; SPEEDRUN = 0;
        repeat (2) @(negedge clk);
    endtask

`ifdef PROG_STORE_BREAKPOINT_EN
    task automatic test_breakpoint;
        int n = 0, h = 0;
        do_write(1'b0, 4'd2, 8'h00);
        fetch_addr = 0; bp_addr = 4'd3; bp_en = 1;
        repeat (2) @(negedge clk);
        SPEEDRUN = 1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (step_en === 1'b1) n++;
            if (bp_hit === 1'b1) h++;
            fetch_addr = (i < 2) ? 4'(i + 1) : 4'd3;
        end
        SPEEDRUN = 0; bp_en = 0;
        checks++; if (n != 3) begin errors++; $display("FAIL bp_steps: got %0d expected 3", n); end
        checks++; if (h != 1) begin errors++; $display("FAIL bp_hit_pulse: got %0d expected 1", h); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL bp_mode: got %0d expected 0", mode); end
    endtask
`endif

    initial begin
        test_reset();
        test_clear();
        test_edit();
        test_run();
        test_step();
        test_speed_halt();
        test_priority();
`ifdef PROG_STORE_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
